// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and helpers for the memory request arbiter
package mem_arb_pkg;

    localparam int DEFAULT_NUM_REQ    = 4;
    localparam int DEFAULT_ADDR_WIDTH = 64;
    // Widest requester vector onehot_of can describe; callers cast down to NUM_REQ bits.
    localparam int MAX_NUM_REQ        = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    function automatic logic [MAX_NUM_REQ-1:0] onehot_of(input int unsigned id);
        return MAX_NUM_REQ'(1) << id;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational round-robin winner search starting at ptr
module rr_priority_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic               valid,
    output logic [IDW-1:0]     winner
);

    logic [2*NUM_REQ-1:0] dbl_req;

    assign dbl_req = {req, req};

    // Lowest set bit at or above ptr in the doubled vector; the upper copy supplies the wrap.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        for (int i = 2*NUM_REQ-1; i >= 0; i--) begin
            if (dbl_req[i] && (i >= int'(ptr))) begin
                valid  = 1'b1;
                winner = (i >= NUM_REQ) ? IDW'(i - NUM_REQ) : IDW'(i);
            end
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// rtl/mem_req_arbiter.sv - round-robin arbiter sharing one AXI request port among cache controllers
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEFAULT_NUM_REQ,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_addr,
    input  logic [NUM_REQ-1:0]            i_wr,
    output logic [NUM_REQ-1:0]            o_done,
    output logic [NUM_REQ-1:0]            o_grant,
    output logic                          o_mem_req,
    output logic [ADDR_WIDTH-1:0]         o_mem_addr,
    output logic                          o_mem_wr,
    input  logic                          i_mem_done,
    output logic                          o_busy
);

    localparam int IDW = $clog2(NUM_REQ);

    arb_state_t            state;
    logic [IDW-1:0]        gnt_id;
    logic [IDW-1:0]        rr_ptr;
    logic                  win_valid;
    logic [IDW-1:0]        win_id;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic                  sel_wr;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_picker (
        .req    (i_req),
        .ptr    (rr_ptr),
        .valid  (win_valid),
        .winner (win_id)
    );

    always_comb begin
        sel_addr = '0;
        sel_wr   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (IDW'(k) == win_id) begin
                sel_addr = i_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wr   = i_wr[k];
            end
        end
    end

    assign o_busy    = (state == ST_BUSY);
    assign o_mem_req = o_busy && !i_mem_done;
    assign o_done    = (o_busy && i_mem_done) ? NUM_REQ'(onehot_of(32'(gnt_id))) : '0;

    // Grant, address and write flag are captured once and frozen until completion.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= ST_IDLE;
            gnt_id     <= '0;
            rr_ptr     <= '0;
            o_grant    <= '0;
            o_mem_addr <= '0;
            o_mem_wr   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win_valid) begin
                        gnt_id     <= win_id;
                        o_grant    <= NUM_REQ'(onehot_of(32'(win_id)));
                        o_mem_addr <= sel_addr;
                        o_mem_wr   <= sel_wr;
                        state      <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (i_mem_done) begin
                        state   <= ST_IDLE;
                        o_grant <= '0;
                        rr_ptr  <= (gnt_id == IDW'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb/tb_mem_req_arbiter.sv - self-checking bench for mem_req_arbiter
module tb_mem_req_arbiter;

    localparam int N  = 4;
    localparam int AW = 64;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req, wr, done, grant;
    logic [N*AW-1:0]   addr;
    logic              mem_req, mem_wr, mem_done, busy;
    logic [AW-1:0]     mem_addr;

    int total = 0;
    int bad   = 0;
    int model_ptr = 0;

    logic [N-1:0]  s_grant, s_done, s_idle_grant;
    logic [AW-1:0] s_addr, s_done_addr;
    logic          s_wr, s_mreq, s_busy, s_mreq_done, s_done_wr, s_idle_busy;
    int            s_early;

    always #5 clk = ~clk;

    mem_req_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_req      (req),
        .i_addr     (addr),
        .i_wr       (wr),
        .o_done     (done),
        .o_grant    (grant),
        .o_mem_req  (mem_req),
        .o_mem_addr (mem_addr),
        .o_mem_wr   (mem_wr),
        .i_mem_done (mem_done),
        .o_busy     (busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int j = 0; j < N; j++) begin
            if (r[(p + j) % N]) return (p + j) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] oh(input int id);
        logic [N-1:0] v;
        v = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    // Runs one transaction whose request is already visible in IDLE; records what the DUT showed.
    task automatic serve(input int lat, input bit scramble);
        tick;
        s_grant = grant; s_addr = mem_addr; s_wr = mem_wr; s_mreq = mem_req; s_busy = busy;
        s_early = (done != '0) ? 1 : 0;
        for (int c = 1; c < lat; c++) begin
            if (scramble) begin
                req = N'($urandom);
                wr  = N'($urandom);
                for (int k = 0; k < N; k++) addr[k*AW +: AW] = {$urandom, $urandom};
            end
            tick;
            if (done != '0) s_early++;
        end
        mem_done = 1'b1;
        #1;
        s_done = done; s_mreq_done = mem_req; s_done_addr = mem_addr; s_done_wr = mem_wr;
        tick;
        mem_done = 1'b0;
        s_idle_grant = grant; s_idle_busy = busy;
    endtask

    task automatic do_reset;
        rst_n = 1'b0; req = '0; wr = '0; addr = '0; mem_done = 1'b0;
        tick; tick;
        rst_n = 1'b1;
        model_ptr = 0;
    endtask

    task automatic test_reset;
        do_reset();
        total++; if (grant !== '0) begin bad++; $display("FAIL reset_grant got=%h want=0", grant); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req got=%b want=0", mem_req); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (mem_addr !== '0) begin bad++; $display("FAIL reset_addr got=%h want=0", mem_addr); end
        total++; if (mem_wr !== 1'b0) begin bad++; $display("FAIL reset_wr got=%b want=0", mem_wr); end
        total++; if (done !== '0) begin bad++; $display("FAIL reset_done got=%h want=0", done); end
    endtask

    task automatic test_single_read;
        req = 4'b0001; addr[0 +: AW] = 64'h1000; wr = '0;
        serve(5, 1'b0);
        total++; if (s_grant !== 4'b0001) begin bad++; $display("FAIL single_grant got=%h want=1", s_grant); end
        total++; if (s_addr !== 64'h1000) begin bad++; $display("FAIL single_addr got=%h want=1000", s_addr); end
        total++; if (s_wr !== 1'b0) begin bad++; $display("FAIL single_wr got=%b want=0", s_wr); end
        total++; if (s_mreq !== 1'b1 || s_busy !== 1'b1) begin bad++; $display("FAIL single_req_busy got=%b%b want=11", s_mreq, s_busy); end
        total++; if (s_early !== 0) begin bad++; $display("FAIL single_early_done got=%0d want=0", s_early); end
        total++; if (s_done !== 4'b0001) begin bad++; $display("FAIL single_done got=%h want=1", s_done); end
        total++; if (s_mreq_done !== 1'b0) begin bad++; $display("FAIL single_req_in_done got=%b want=0", s_mreq_done); end
        total++; if (s_idle_grant !== '0 || s_idle_busy !== 1'b0) begin bad++; $display("FAIL single_idle got=%h/%b want=0/0", s_idle_grant, s_idle_busy); end
        model_ptr = 1;
        req = 4'b0011;
        serve(1, 1'b0);
        total++; if (s_grant !== 4'b0010) begin bad++; $display("FAIL single_ptr_advanced got=%h want=2", s_grant); end
        model_ptr = 2;
        req = '0;
    endtask

    task automatic test_round_robin;
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            serve(3, 1'b0);
            total++; if (s_grant !== oh(i % N)) begin bad++; $display("FAIL rr_grant_%0d got=%h want=%h", i, s_grant, oh(i % N)); end
            total++; if (s_done !== oh(i % N)) begin bad++; $display("FAIL rr_done_%0d got=%h want=%h", i, s_done, oh(i % N)); end
            total++; if (s_idle_grant !== '0 || s_idle_busy !== 1'b0) begin bad++; $display("FAIL rr_idle_gap_%0d got=%h/%b want=0/0", i, s_idle_grant, s_idle_busy); end
        end
        model_ptr = 1;
        req = '0;
    endtask

    task automatic test_wrap_skip;
        do_reset();
        req = 4'b0100;
        serve(1, 1'b0);
        total++; if (s_grant !== 4'b0100) begin bad++; $display("FAIL wrap_setup got=%h want=4", s_grant); end
        req = 4'b0101;
        serve(2, 1'b0);
        total++; if (s_grant !== 4'b0001) begin bad++; $display("FAIL wrap_first got=%h want=1", s_grant); end
        serve(2, 1'b0);
        total++; if (s_grant !== 4'b0100) begin bad++; $display("FAIL wrap_second got=%h want=4", s_grant); end
        model_ptr = 3;
        req = '0;
    endtask

    task automatic test_frozen;
        req = 4'b0100; addr[2*AW +: AW] = 64'h2040; wr = 4'b0100;
        tick;
        total++; if (grant !== 4'b0100 || mem_addr !== 64'h2040 || mem_wr !== 1'b1) begin bad++; $display("FAIL frozen_grant got=%h/%h/%b want=4/2040/1", grant, mem_addr, mem_wr); end
        addr[2*AW +: AW] = 64'hFFE0; req = '0; wr = '0;
        tick; tick;
        total++; if (mem_addr !== 64'h2040) begin bad++; $display("FAIL frozen_addr got=%h want=2040", mem_addr); end
        total++; if (mem_wr !== 1'b1) begin bad++; $display("FAIL frozen_wr got=%b want=1", mem_wr); end
        total++; if (busy !== 1'b1 || mem_req !== 1'b1 || grant !== 4'b0100) begin bad++; $display("FAIL frozen_busy got=%b%b/%h want=11/4", busy, mem_req, grant); end
        mem_done = 1'b1;
        #1;
        total++; if (done !== 4'b0100) begin bad++; $display("FAIL frozen_done got=%h want=4", done); end
        tick;
        mem_done = 1'b0;
        model_ptr = 3;
    endtask

    task automatic test_spurious_done;
        req = '0;
        mem_done = 1'b1;
        #1;
        total++; if (done !== '0) begin bad++; $display("FAIL spurious_done got=%h want=0", done); end
        tick;
        mem_done = 1'b0;
        total++; if (busy !== 1'b0 || grant !== '0) begin bad++; $display("FAIL spurious_state got=%b/%h want=0/0", busy, grant); end
        req = 4'b1111;
        serve(2, 1'b0);
        total++; if (s_grant !== oh(model_ptr)) begin bad++; $display("FAIL spurious_ptr_kept got=%h want=%h", s_grant, oh(model_ptr)); end
        model_ptr = (model_ptr + 1) % N;
        req = '0;
    endtask

    task automatic test_random;
        logic [N-1:0]  r, wv, eg;
        logic [AW-1:0] av [N];
        int win, lat;
        for (int it = 0; it < 40; it++) begin
            r  = N'($urandom_range(0, 15));
            wv = N'($urandom);
            for (int k = 0; k < N; k++) begin
                av[k] = {$urandom, $urandom} & ~64'h3F;
                addr[k*AW +: AW] = av[k];
            end
            req = r; wr = wv;
            win = pick(r, model_ptr);
            if (win < 0) begin
                tick;
                total++; if (grant !== '0 || busy !== 1'b0) begin bad++; $display("FAIL rand_idle_%0d got=%h/%b want=0/0", it, grant, busy); end
            end else begin
                lat = $urandom_range(1, 4);
                serve(lat, 1'b1);
                eg = oh(win);
                total++; if (s_grant !== eg) begin bad++; $display("FAIL rand_grant_%0d got=%h want=%h", it, s_grant, eg); end
                total++; if (s_addr !== av[win] || s_done_addr !== av[win]) begin bad++; $display("FAIL rand_addr_%0d got=%h/%h want=%h", it, s_addr, s_done_addr, av[win]); end
                total++; if (s_wr !== wv[win] || s_done_wr !== wv[win]) begin bad++; $display("FAIL rand_wr_%0d got=%b/%b want=%b", it, s_wr, s_done_wr, wv[win]); end
                total++; if (s_done !== eg || s_early !== 0) begin bad++; $display("FAIL rand_done_%0d got=%h/%0d want=%h/0", it, s_done, s_early, eg); end
                total++; if (s_mreq_done !== 1'b0 || s_idle_grant !== '0) begin bad++; $display("FAIL rand_release_%0d got=%b/%h want=0/0", it, s_mreq_done, s_idle_grant); end
                model_ptr = (win + 1) % N;
            end
        end
        req = '0;
    endtask

    task automatic test_reset_mid;
        req = 4'b0100; addr[2*AW +: AW] = 64'h3000; wr = 4'b0100;
        tick; tick;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rstmid_setup got=%b want=1", busy); end
        rst_n = 1'b0; mem_done = 1'b1;
        #1;
        total++; if (grant !== '0 || mem_req !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rstmid_ctrl got=%h/%b/%b want=0/0/0", grant, mem_req, busy); end
        total++; if (mem_addr !== '0 || done !== '0) begin bad++; $display("FAIL rstmid_data got=%h/%h want=0/0", mem_addr, done); end
        tick;
        mem_done = 1'b0; rst_n = 1'b1;
        req = 4'b1000;
        serve(2, 1'b0);
        total++; if (s_grant !== 4'b1000) begin bad++; $display("FAIL rstmid_regrant got=%h want=8", s_grant); end
        req = '0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_wrap_skip();
        test_frozen();
        test_spurious_done();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_req_arbiter.md
# mem_req_arbiter

Round-robin arbiter that shares the single AXI memory-request port between the per-core instruction and data cache controllers. Each cache controller raises a level request with a block-aligned address when it misses. The arbiter grants one requester at a time and forwards its latched address to the AXI module. It routes the AXI completion pulse back to the granted requester only. It sits between the cache controllers of all cores and the one AXI master.

## Interface
- NUM_REQ, 4, number of requesters (2 cores × I/D); must be ≥ 2, need not be a power of two
- ADDR_WIDTH, 64, request address width
- i_clk  in  1  clock, all logic on rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_req  in  NUM_REQ  per-requester level request, held until its o_done
- i_addr  in  NUM_REQ×ADDR_WIDTH  packed per-requester block-aligned address, requester k at bits [k*ADDR_WIDTH +: ADDR_WIDTH]
- i_wr  in  NUM_REQ  per-requester write (writeback) flag, 0 = block read
- o_done  out  NUM_REQ  completion pulse to the granted requester
- o_grant  out  NUM_REQ  one-hot grant, registered, all-zero when idle; external data muxes steer on it
- o_mem_req  out  1  request to AXI module
- o_mem_addr  out  ADDR_WIDTH  latched address of granted requester
- o_mem_wr  out  1  latched write flag of granted requester
- i_mem_done  in  1  AXI transaction complete, single-cycle pulse
- o_busy  out  1  high while a transaction is granted

## Operation
- States: IDLE, BUSY. Registers: state, gnt_id (clog2 NUM_REQ), rr_ptr (clog2 NUM_REQ), o_grant, o_mem_addr, o_mem_wr.
- Reset (any time, including mid-transaction): state=IDLE, rr_ptr=0, gnt_id=0, o_grant=0, o_mem_addr=0, o_mem_wr=0. As a result o_mem_req, o_done and o_busy are all 0. An in-flight AXI completion is not replayed.
- IDLE, with no request (i_req==0): hold.
- IDLE, with any request: the winner is the first set bit at or after rr_ptr, searching upward with wrap modulo NUM_REQ. On the clock edge:
  - gnt_id=winner
  - o_grant=onehot(winner)
  - o_mem_addr=i_addr[winner]
  - o_mem_wr=i_wr[winner]
  - state=BUSY
- BUSY outputs: o_busy=1; o_mem_req = !i_mem_done (combinational, drops in the done cycle); o_done[gnt_id] = i_mem_done (combinational); all other o_done bits 0.
- BUSY, on i_mem_done: on the next edge, state=IDLE, o_grant=0, rr_ptr=(gnt_id+1) mod NUM_REQ. o_mem_addr and o_mem_wr hold their values.
- Address, write flag and grant are frozen for the whole transaction. Changes on i_addr, i_wr or i_req during BUSY have no effect.
- If a requester drops i_req while granted, the transaction still runs to i_mem_done and o_done still pulses. AXI transfers are not abortable.
- i_mem_done in IDLE is ignored: no o_done, no state change.
- Invariants: o_grant is one-hot or zero; at most one o_done bit is set, and only while in BUSY.

## Timing
- Grant latency: a request sampled in IDLE at edge N gives o_grant and o_mem_req high in cycle N+1.
- o_done is in the same cycle as i_mem_done (zero latency).
- Minimum one IDLE cycle after each completion. Back-to-back throughput is one transaction per (AXI latency + 2) cycles.
- The IDLE gap lets a cache controller sit in its update-cache cycle with its request low. A stale request is never re-granted.
- Fairness: with all NUM_REQ requesting continuously, each is granted once every NUM_REQ transactions.

## Structure
- Package mem_arb_pkg holds:
  - the state enum (IDLE, BUSY)
  - default ADDR_WIDTH and NUM_REQ localparams
  - a function onehot_of(id)
- Sub-module rr_priority_picker, purely combinational:
  - inputs: req vector and ptr
  - outputs: valid and winner index
  - parameterised on NUM_REQ, implemented as a double-width masked priority search.
- Address mux and FSM stay in mem_req_arbiter.

## Test plan
- Single read: i_req=4'b0001, i_addr[0]=0x1000, i_mem_done 5 cycles after grant. Expect:
  - o_grant=0001 one cycle later
  - o_mem_addr=0x1000, o_mem_wr=0
  - o_done[0] coincident with i_mem_done
  - o_mem_req low in the done cycle
  - rr_ptr=1 afterwards
- Round robin: i_req=4'b1111 held, each request completed after 3 cycles. Expect grant order 0,1,2,3,0 with exactly one IDLE cycle between grants.
- Wrap and skip: rr_ptr=3, i_req=4'b0101. Expect grant to requester 0, then 2.
- Frozen request: requester 2 granted with address 0x2040 and i_wr=1. i_addr[2] then changes to 0xFFE0 and i_req[2] drops mid-transaction. Expect o_mem_addr to stay 0x2040, o_mem_wr=1, and o_done[2] to still pulse on i_mem_done.
- Spurious done: i_mem_done pulsed in IDLE with i_req=0. Expect o_done=0, state IDLE, rr_ptr unchanged.
- Reset mid-transaction: assert i_rst_n=0 during BUSY. Expect o_grant, o_mem_req, o_busy, o_mem_addr and o_done to all go 0 immediately. After reset release with i_req=4'b1000, expect the grant to go to requester 3 (search from rr_ptr=0).
